// File: rtl/byte_unstriping_pkg.sv
// Shared PHY definitions for the lane striping / unstriping pair.
// Both sides use the same phase meaning, so they agree on lane order.
package byte_unstriping_pkg;

  localparam int unsigned BYTE_WIDTH = 8;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  // Phase 0 is the edge where a lane pair is captured and lane 1 is emitted.
  // Phase 1 is the edge where lane 0 is emitted.
  typedef enum logic {
    PH_CAPTURE    = 1'b0,
    PH_EMIT_LANE0 = 1'b1
  } phase_t;

endpackage

// File: rtl/byte_unstriping.sv
// Receive-side lane merger: interleaves two clk_f lanes into one clk_2f
// byte stream (lane 0 first), tracks link activity and flags pairs where
// lane 1 is valid without lane 0.
module byte_unstriping
  import byte_unstriping_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = BYTE_WIDTH
) (
  input  logic                  clk_2f,
  input  logic                  reset_L,
  input  logic [DATA_WIDTH-1:0] data_lane_0,
  input  logic                  valid_lane_0,
  input  logic [DATA_WIDTH-1:0] data_lane_1,
  input  logic                  valid_lane_1,
  output logic [DATA_WIDTH-1:0] data_unstripped,
  output logic                  valid_unstripped,
  output logic                  active,
  output logic                  err_order
);

  state_t                state;
  state_t                state_next;
  phase_t                phase;
  logic [DATA_WIDTH-1:0] hold_0;
  logic [DATA_WIDTH-1:0] hold_1;
  logic                  hold_v0;
  logic                  hold_v1;
  logic                  capture;
  logic                  order_violation;

  assign capture         = (phase == PH_CAPTURE);
  assign order_violation = valid_lane_1 & ~valid_lane_0;
  assign active          = (state == ST_ACTIVE);

  // Link state register.
  always_ff @(posedge clk_2f or negedge reset_L) begin
    if (!reset_L) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Link state only moves on capture edges; an order violation is neither
  // a start nor an all-invalid pair, so it leaves the state alone.
  always_comb begin
    state_next = state;
    if (capture) begin
      unique case (state)
        ST_IDLE:   if (valid_lane_0) state_next = ST_ACTIVE;
        ST_ACTIVE: if (!valid_lane_0 && !valid_lane_1) state_next = ST_IDLE;
        default:   state_next = ST_IDLE;
      endcase
    end
  end

  // Phase toggle, pair capture, slot emission and sticky order error.
  always_ff @(posedge clk_2f or negedge reset_L) begin
    if (!reset_L) begin
      phase            <= PH_CAPTURE;
      hold_0           <= '0;
      hold_1           <= '0;
      hold_v0          <= 1'b0;
      hold_v1          <= 1'b0;
      data_unstripped  <= '0;
      valid_unstripped <= 1'b0;
      err_order        <= 1'b0;
    end else begin
      phase <= capture ? PH_EMIT_LANE0 : PH_CAPTURE;
      if (capture) begin
        // Lane 1 of the previous pair leaves on the same edge the next
        // pair is taken in, which keeps the output free of bubbles.
        data_unstripped  <= hold_v1 ? hold_1 : '0;
        valid_unstripped <= hold_v1;
        hold_0           <= data_lane_0;
        hold_v0          <= valid_lane_0;
        hold_1           <= data_lane_1;
        hold_v1          <= valid_lane_1 & valid_lane_0;
        if (order_violation) begin
          err_order <= 1'b1;
        end
      end else begin
        data_unstripped  <= hold_v0 ? hold_0 : '0;
        valid_unstripped <= hold_v0;
      end
    end
  end

endmodule

// File: tb/tb_byte_unstriping.sv
// Directed bench for byte_unstriping: each pair of lane bytes is held for
// two clk_2f edges, outputs are sampled 1 time unit after every edge.
module tb_byte_unstriping;

  logic       clk_2f = 1'b0;
  logic       reset_L = 1'b0;
  logic [7:0] data_lane_0 = '0;
  logic       valid_lane_0 = 1'b0;
  logic [7:0] data_lane_1 = '0;
  logic       valid_lane_1 = 1'b0;
  logic [7:0] data_unstripped;
  logic       valid_unstripped;
  logic       active;
  logic       err_order;

  int checks = 0;
  int errors = 0;

  logic [7:0] s_data   [0:31];
  logic       s_valid  [0:31];
  logic       s_active [0:31];
  logic       s_err    [0:31];
  int         n_samp = 0;

  always #5 clk_2f = ~clk_2f;

  byte_unstriping #(.DATA_WIDTH(8)) dut (
    .clk_2f          (clk_2f),
    .reset_L         (reset_L),
    .data_lane_0     (data_lane_0),
    .valid_lane_0    (valid_lane_0),
    .data_lane_1     (data_lane_1),
    .valid_lane_1    (valid_lane_1),
    .data_unstripped (data_unstripped),
    .valid_unstripped(valid_unstripped),
    .active          (active),
    .err_order       (err_order)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Present one lane pair for a capture edge and the following emit edge.
  task automatic run_pair(input logic [7:0] d0, input logic v0,
                          input logic [7:0] d1, input logic v1);
    data_lane_0  = d0;
    valid_lane_0 = v0;
    data_lane_1  = d1;
    valid_lane_1 = v1;
    repeat (2) begin
      @(posedge clk_2f);
      #1;
      s_data[n_samp]   = data_unstripped;
      s_valid[n_samp]  = valid_unstripped;
      s_active[n_samp] = active;
      s_err[n_samp]    = err_order;
      n_samp++;
    end
  endtask

  // Reset between edges and release between edges so the next edge is a capture.
  task automatic apply_reset();
    @(posedge clk_2f);
    #3;
    reset_L      = 1'b0;
    data_lane_0  = '0;
    valid_lane_0 = 1'b0;
    data_lane_1  = '0;
    valid_lane_1 = 1'b0;
    repeat (2) @(posedge clk_2f);
    #3;
    reset_L = 1'b1;
    n_samp  = 0;
  endtask

  task automatic test_reset();
    apply_reset();
    run_pair(8'h77, 1'b0, 8'h55, 1'b1);
    run_pair(8'h5A, 1'b1, 8'h6B, 1'b1);
    checks++;
    if (s_valid[3] !== 1'b1 || s_data[3] !== 8'h5A || s_err[3] !== 1'b1) begin
      errors++;
      $display("FAIL reset_pre: got v=%b d=%h e=%b want v=1 d=5a e=1", s_valid[3], s_data[3], s_err[3]);
    end
    #2;
    reset_L = 1'b0;
    #1;
    checks++;
    if (data_unstripped !== 8'h00) begin
      errors++;
      $display("FAIL reset_async_data: got %h want 00", data_unstripped);
    end
    checks++;
    if (valid_unstripped !== 1'b0) begin
      errors++;
      $display("FAIL reset_async_valid: got %b want 0", valid_unstripped);
    end
    checks++;
    if (active !== 1'b0) begin
      errors++;
      $display("FAIL reset_async_active: got %b want 0", active);
    end
    checks++;
    if (err_order !== 1'b0) begin
      errors++;
      $display("FAIL reset_async_err: got %b want 0", err_order);
    end
    repeat (2) @(posedge clk_2f);
    #3;
    reset_L = 1'b1;
    n_samp  = 0;
    run_pair(8'h5A, 1'b1, 8'h6B, 1'b1);
    run_pair(8'h00, 1'b0, 8'h00, 1'b0);
    checks++;
    if (s_valid[0] !== 1'b0 || s_active[0] !== 1'b1) begin
      errors++;
      $display("FAIL reset_first_capture: got v=%b a=%b want v=0 a=1", s_valid[0], s_active[0]);
    end
    checks++;
    if (s_valid[1] !== 1'b1 || s_data[1] !== 8'h5A) begin
      errors++;
      $display("FAIL reset_lane0: got v=%b d=%h want v=1 d=5a", s_valid[1], s_data[1]);
    end
    checks++;
    if (s_valid[2] !== 1'b1 || s_data[2] !== 8'h6B) begin
      errors++;
      $display("FAIL reset_lane1: got v=%b d=%h want v=1 d=6b", s_valid[2], s_data[2]);
    end
  endtask

  task automatic test_steady();
    logic [7:0] exp_d [0:7];
    logic       exp_v [0:7];
    logic       exp_a [0:7];
    exp_d = '{8'h00, 8'hA1, 8'hB1, 8'hA2, 8'hB2, 8'h00, 8'h00, 8'h00};
    exp_v = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    exp_a = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    apply_reset();
    run_pair(8'hA1, 1'b1, 8'hB1, 1'b1);
    run_pair(8'hA2, 1'b1, 8'hB2, 1'b1);
    run_pair(8'h00, 1'b0, 8'h00, 1'b0);
    run_pair(8'h00, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (s_data[i] !== exp_d[i] || s_valid[i] !== exp_v[i] ||
          s_active[i] !== exp_a[i] || s_err[i] !== 1'b0) begin
        errors++;
        $display("FAIL steady[%0d]: got d=%h v=%b a=%b e=%b want d=%h v=%b a=%b e=0",
                 i, s_data[i], s_valid[i], s_active[i], s_err[i], exp_d[i], exp_v[i], exp_a[i]);
      end
    end
  endtask

  task automatic test_odd_length();
    logic [7:0] exp_d [0:5];
    logic       exp_v [0:5];
    logic       exp_a [0:5];
    exp_d = '{8'h00, 8'hC0, 8'h00, 8'h00, 8'h00, 8'h00};
    exp_v = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    exp_a = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    apply_reset();
    run_pair(8'hC0, 1'b1, 8'h99, 1'b0);
    run_pair(8'h5A, 1'b0, 8'h6B, 1'b0);
    run_pair(8'h00, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (s_data[i] !== exp_d[i] || s_valid[i] !== exp_v[i] ||
          s_active[i] !== exp_a[i] || s_err[i] !== 1'b0) begin
        errors++;
        $display("FAIL odd[%0d]: got d=%h v=%b a=%b e=%b want d=%h v=%b a=%b e=0",
                 i, s_data[i], s_valid[i], s_active[i], s_err[i], exp_d[i], exp_v[i], exp_a[i]);
      end
    end
  endtask

  task automatic test_order_error();
    logic [7:0] exp_d [0:5];
    logic       exp_v [0:5];
    logic       exp_a [0:5];
    exp_d = '{8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h00};
    exp_v = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    exp_a = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    apply_reset();
    run_pair(8'h77, 1'b0, 8'h55, 1'b1);
    run_pair(8'h11, 1'b1, 8'h22, 1'b1);
    run_pair(8'h00, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (s_data[i] !== exp_d[i] || s_valid[i] !== exp_v[i] ||
          s_active[i] !== exp_a[i] || s_err[i] !== 1'b1) begin
        errors++;
        $display("FAIL order[%0d]: got d=%h v=%b a=%b e=%b want d=%h v=%b a=%b e=1",
                 i, s_data[i], s_valid[i], s_active[i], s_err[i], exp_d[i], exp_v[i], exp_a[i]);
      end
    end
  endtask

  task automatic test_idle_gaps();
    logic [7:0] exp_d [0:9];
    logic       exp_v [0:9];
    logic       exp_a [0:9];
    exp_d = '{8'h00, 8'h31, 8'h32, 8'h00, 8'h00, 8'h00, 8'h00, 8'h33, 8'h44, 8'h00};
    exp_v = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    exp_a = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    apply_reset();
    run_pair(8'h31, 1'b1, 8'h32, 1'b1);
    run_pair(8'hEE, 1'b0, 8'hFF, 1'b0);
    run_pair(8'hEE, 1'b0, 8'hFF, 1'b0);
    run_pair(8'h33, 1'b1, 8'h44, 1'b1);
    run_pair(8'h00, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (s_data[i] !== exp_d[i] || s_valid[i] !== exp_v[i] ||
          s_active[i] !== exp_a[i] || s_err[i] !== 1'b0) begin
        errors++;
        $display("FAIL gaps[%0d]: got d=%h v=%b a=%b e=%b want d=%h v=%b a=%b e=0",
                 i, s_data[i], s_valid[i], s_active[i], s_err[i], exp_d[i], exp_v[i], exp_a[i]);
      end
    end
  endtask

  // Back-to-back pairs routed through a 1:2 demux model must reproduce the
  // transmit-side lane contents.
  task automatic test_back_to_back();
    logic [7:0] tx_a [0:3];
    logic [7:0] tx_b [0:3];
    logic [7:0] rx_0 [0:7];
    logic [7:0] rx_1 [0:7];
    int         n0;
    int         n1;
    logic       sel;
    tx_a = '{8'hA3, 8'hA4, 8'hA5, 8'hA6};
    tx_b = '{8'hB3, 8'hB4, 8'hB5, 8'hB6};
    n0   = 0;
    n1   = 0;
    sel  = 1'b0;
    apply_reset();
    for (int k = 0; k < 4; k++) run_pair(tx_a[k], 1'b1, tx_b[k], 1'b1);
    run_pair(8'h00, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 10; i++) begin
      if (s_valid[i] === 1'b1) begin
        if (!sel) begin rx_0[n0] = s_data[i]; n0++; end
        else      begin rx_1[n1] = s_data[i]; n1++; end
        sel = ~sel;
      end
    end
    checks++;
    if (n0 != 4 || n1 != 4) begin
      errors++;
      $display("FAIL chain_count: got lane0=%0d lane1=%0d want 4 4", n0, n1);
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (rx_0[k] !== tx_a[k] || rx_1[k] !== tx_b[k]) begin
          errors++;
          $display("FAIL chain[%0d]: got %h/%h want %h/%h", k, rx_0[k], rx_1[k], tx_a[k], tx_b[k]);
        end
      end
    end
    for (int i = 1; i < 9; i++) begin
      checks++;
      if (s_valid[i] !== 1'b1) begin
        errors++;
        $display("FAIL chain_bubble[%0d]: got valid=%b want 1", i, s_valid[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_steady();
    test_odd_length();
    test_order_error();
    test_idle_gaps();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
